// File: rtl/excess3_seq_if.sv
// Digit handshake and result bus between a serial excess-3 BCD source and the decoder.
// The master drives start/digits; the slave (decoder) returns the handshake, status and result.
interface excess3_seq_if #(
  parameter int BW = 14
);
  logic          start;
  logic          digit_valid;
  logic [3:0]    digit_in;
  logic          digit_ready;
  logic          done;
  logic          busy;
  logic [BW-1:0] bin_out;
  logic          error;

  modport master (
    output start, digit_valid, digit_in,
    input  digit_ready, done, busy, bin_out, error
  );

  modport slave (
    input  start, digit_valid, digit_in,
    output digit_ready, done, busy, bin_out, error
  );
endinterface

// File: rtl/excess3_seq_decoder.sv
// Multi-digit excess-3 to binary converter, MSD first, acc = acc*10 + d per accepted digit.
// Optional invalid-code detection and ERR state: define EXCESS3_ERR_CHECK_EN.
module excess3_seq_decoder #(
  parameter int NDIGITS = 4,
  parameter int BW      = 14
) (
  input  logic         clk,
  input  logic         rst_n,
  excess3_seq_if.slave bus
);
  localparam int CW = $clog2(NDIGITS) + 1;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] COLLECT = 2'd1;
  localparam logic [1:0] FINISH  = 2'd2;
`ifdef EXCESS3_ERR_CHECK_EN
  localparam logic [1:0] ERR     = 2'd3;
`endif

  logic [1:0]    state_reg, state_next;
  logic [BW-1:0] acc_reg, acc_next;
  logic [BW-1:0] bin_reg, bin_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic          done_reg, done_next;
  logic [3:0]    d;
  logic          xfer;

  assign d    = bus.digit_in - 4'd3;
  assign xfer = bus.digit_valid && (state_reg == COLLECT);

`ifdef EXCESS3_ERR_CHECK_EN
  logic        err_reg, err_next;
  logic [15:0] valid_lut;
  logic        code_ok;

  // Legal excess-3 codes are 0011..1100; everything else flags an error.
  for (genvar gi = 0; gi < 16; gi++) begin : g_valid_lut
    assign valid_lut[gi] = (gi >= 3) && (gi <= 12);
  end
  assign code_ok = valid_lut[bus.digit_in];
`endif

  always_comb begin
    state_next = state_reg;
    acc_next   = acc_reg;
    cnt_next   = cnt_reg;
    bin_next   = bin_reg;
    done_next  = 1'b0;
`ifdef EXCESS3_ERR_CHECK_EN
    err_next   = err_reg;
`endif
    case (state_reg)
      IDLE: begin
        if (bus.start) begin
          acc_next   = '0;
          cnt_next   = '0;
`ifdef EXCESS3_ERR_CHECK_EN
          err_next   = 1'b0;
`endif
          state_next = COLLECT;
        end
      end
      COLLECT: begin
`ifdef EXCESS3_ERR_CHECK_EN
        if (xfer && !code_ok) begin
          err_next   = 1'b1;
          state_next = ERR;
        end else
`endif
        if (xfer) begin
          acc_next = acc_reg * BW'(10) + BW'(d);
          cnt_next = cnt_reg + 1'b1;
          if (cnt_reg == CW'(NDIGITS - 1)) begin
            state_next = FINISH;
          end
        end
      end
      FINISH: begin
        // Result and done are registered here so both appear one edge after the last digit.
        bin_next   = acc_reg;
        done_next  = 1'b1;
        state_next = IDLE;
      end
`ifdef EXCESS3_ERR_CHECK_EN
      ERR: begin
        if (bus.start) begin
          acc_next   = '0;
          cnt_next   = '0;
          err_next   = 1'b0;
          state_next = COLLECT;
        end
      end
`endif
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      acc_reg   <= '0;
      cnt_reg   <= '0;
      bin_reg   <= '0;
      done_reg  <= 1'b0;
`ifdef EXCESS3_ERR_CHECK_EN
      err_reg   <= 1'b0;
`endif
    end else begin
      state_reg <= state_next;
      acc_reg   <= acc_next;
      cnt_reg   <= cnt_next;
      bin_reg   <= bin_next;
      done_reg  <= done_next;
`ifdef EXCESS3_ERR_CHECK_EN
      err_reg   <= err_next;
`endif
    end
  end

  assign bus.digit_ready = (state_reg == COLLECT);
  assign bus.busy        = (state_reg == COLLECT);
  assign bus.done        = done_reg;
  assign bus.bin_out     = bin_reg;
`ifdef EXCESS3_ERR_CHECK_EN
  assign bus.error       = err_reg;
`else
  assign bus.error       = 1'b0;
`endif
endmodule
